mc_control_fsm: RTL
===================

# mc_control_fsm

Main control unit for the multi-cycle CPU: a Moore state machine that sequences the shared datapath (single memory, one ALU, register file, PC/IR/MDR/A/B/ALUOut holding registers) through fetch, decode, execute, memory and write-back steps. It decodes the 6-bit opcode latched in the IR and drives every datapath enable and mux select. It also keeps a retired-instruction counter and flags illegal opcodes. It is instantiated inside `CPU` between the IR and the datapath muxes.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter

Ports:
- Clk  in  1  system clock, rising-edge
- Reset  in  1  asynchronous, active-high reset
- Op  in  6  opcode field IR[31:26]
- Zero  in  1  ALU zero flag, used in BRANCH
- PCEn  out  1  PC load enable = PCWrite | (PCWriteCond & Zero)
- IorD  out  1  memory address select: 0=PC, 1=ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR load enable
- MemtoReg  out  1  register write data: 0=ALUOut, 1=MDR
- RegDst  out  1  destination register: 0=rt, 1=rd
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  0=PC, 1=A
- ALUSrcB  out  2  0=B, 1=const 4, 2=signext imm, 3=signext imm<<2
- ALUOp  out  2  0=add, 1=sub, 2=use funct
- PCSource  out  2  0=ALU result, 1=ALUOut, 2=jump target
- State  out  4  current state encoding (debug)
- Illegal  out  1  one-cycle pulse: undecodable opcode
- InstrCount  out  CNT_W  instructions retired

## Operation
- Recognised opcodes: R-type 000000, LW 100011, SW 101011, BEQ 000100, J 000010, ADDI 001000.
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11. Encodings 12–15 are unreachable; if entered, next state is FETCH and all strobes are 0.
- FETCH: MemRead=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=1, ALUOp=0, PCSource=0, PCWrite=1 -> DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=0. Next state: LW/SW -> MEMADR; R -> EXEC; BEQ -> BRANCH; J -> JUMP; ADDI -> ADDIEX; any other opcode -> FETCH with Illegal=1.
- MEMADR: ALUSrcA=1, ALUSrcB=2, ALUOp=0 -> MEMRD (LW) or MEMWR (SW).
- MEMRD: MemRead=1, IorD=1 -> MEMWB. MEMWB: RegWrite=1, MemtoReg=1, RegDst=0 -> FETCH.
- MEMWR: MemWrite=1, IorD=1 -> FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=0, ALUOp=2 -> ALUWB. ALUWB: RegWrite=1, MemtoReg=0, RegDst=1 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=1, PCWriteCond=1, PCSource=1 -> FETCH.
- JUMP: PCWrite=1, PCSource=2 -> FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=2, ALUOp=0 -> ADDIWB. ADDIWB: RegWrite=1, MemtoReg=0, RegDst=0 -> FETCH.
- Outputs not listed for a state are 0.
- Retirement: InstrCount increments by 1 on each clock edge leaving MEMWB, MEMWR, ALUWB, BRANCH (taken or not), JUMP or ADDIWB. Illegal opcodes are not counted. The counter wraps from 2^CNT_W−1 to 0 with no flag.

## Timing
- Reset asserted: the state goes to FETCH and InstrCount to 0 immediately, without waiting for a clock edge. While Reset is high, every strobe (PCEn, MemRead, MemWrite, IRWrite, RegWrite, Illegal) is forced to 0. Muxes hold their FETCH values; State reads 0.
- First rising edge after Reset deasserts: FETCH is active, so the first instruction loads on that edge.
- All outputs are Moore-decoded from the state register, except PCEn (depends on Zero) and Illegal (depends on Op in DECODE).
- Cycles per instruction: LW 5; SW, R-type, ADDI 4; BEQ, J 3; illegal opcode 2.
- Reset mid-instruction abandons it with no write strobe, even when asserted in MEMWR, ALUWB or MEMWB. InstrCount is not incremented.
- Op is sampled only in DECODE and MEMADR. Changes to Op in other states have no effect.

## Test plan
- Reset held for 10 cycles, then released -> all strobes 0 during reset. Next edge: State=0, MemRead=1, IRWrite=1, PCEn=1. State=1 one cycle later.
- LW then SW (Op=100011, then 101011) -> states 0,1,2,3,4 then 0,1,2,5. MemtoReg=1 and RegWrite=1 only in state 4; MemWrite=1 only in state 5. InstrCount ends at 2.
- BEQ with Zero=1, then with Zero=0 -> PCEn=1 in BRANCH only when Zero=1. Both take 3 cycles; InstrCount increments for both.
- R-type, ADDI, J -> R path 0,1,6,7 with ALUOp=2 in state 6 and RegDst=1 in state 7. ADDI path 0,1,10,11 with RegDst=0. J path 0,1,9 with PCSource=2 and PCEn=1.
- Op=111111 -> Illegal=1 for exactly one cycle in DECODE, then FETCH, no RegWrite/MemWrite, InstrCount unchanged.
- Reset asserted asynchronously mid-cycle in MEMWR, with CNT_W=4 and the counter preloaded to 15 via 15 retirements -> MemWrite drops to 0 immediately and InstrCount reads 0. Separately, a 16th retirement wraps InstrCount from 15 to 0.

Source files
------------

// File: rtl/mc_control_fsm.sv
// Main control unit of the multi-cycle CPU: Moore sequencer for the shared
// datapath, with an illegal-opcode pulse and a retired-instruction counter.
module mc_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [5:0]       Op,
  input  logic             Zero,
  output logic             PCEn,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       State,
  output logic             Illegal,
  output logic [CNT_W-1:0] InstrCount
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state;
  state_t next_state;

  logic       pc_write;
  logic       pc_write_cond;
  logic       iord_d;
  logic       mem_read_d;
  logic       mem_write_d;
  logic       ir_write_d;
  logic       memto_reg_d;
  logic       reg_dst_d;
  logic       reg_write_d;
  logic       alu_src_a_d;
  logic [1:0] alu_src_b_d;
  logic [1:0] alu_op_d;
  logic [1:0] pc_source_d;
  logic       illegal_d;
  logic       retire;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state    = S_FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord_d        = 1'b0;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    ir_write_d    = 1'b0;
    memto_reg_d   = 1'b0;
    reg_dst_d     = 1'b0;
    reg_write_d   = 1'b0;
    alu_src_a_d   = 1'b0;
    alu_src_b_d   = 2'd0;
    alu_op_d      = 2'd0;
    pc_source_d   = 2'd0;
    illegal_d     = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read_d  = 1'b1;
        ir_write_d  = 1'b1;
        alu_src_b_d = 2'd1;
        pc_write    = 1'b1;
        next_state  = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b_d = 2'd3;
        case (Op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_R:         next_state = S_EXEC;
          OP_BEQ:       next_state = S_BRANCH;
          OP_J:         next_state = S_JUMP;
          OP_ADDI:      next_state = S_ADDIEX;
          default: begin
            next_state = S_FETCH;
            illegal_d  = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = 2'd2;
        // Op is re-read here to pick the load or store branch.
        next_state  = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read_d = 1'b1;
        iord_d     = 1'b1;
        next_state = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write_d = 1'b1;
        memto_reg_d = 1'b1;
      end
      S_MEMWR: begin
        mem_write_d = 1'b1;
        iord_d      = 1'b1;
      end
      S_EXEC: begin
        alu_src_a_d = 1'b1;
        alu_op_d    = 2'd2;
        next_state  = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_d = 1'b1;
        reg_dst_d   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_d   = 1'b1;
        alu_op_d      = 2'd1;
        pc_write_cond = 1'b1;
        pc_source_d   = 2'd1;
      end
      S_JUMP: begin
        pc_write    = 1'b1;
        pc_source_d = 2'd2;
      end
      S_ADDIEX: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = 2'd2;
        next_state  = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_d = 1'b1;
      end
      default: begin
        next_state = S_FETCH;
      end
    endcase
  end

  // Every completing state returns to FETCH, so leaving it is one retirement.
  assign retire = (state == S_MEMWB) || (state == S_MEMWR) || (state == S_ALUWB) ||
                  (state == S_BRANCH) || (state == S_JUMP) || (state == S_ADDIWB);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      InstrCount <= '0;
    end else if (retire) begin
      InstrCount <= InstrCount + CNT_ONE;
    end
  end

  // Strobes are masked by Reset so nothing fires while the state is forced.
  assign PCEn     = ~Reset & (pc_write | (pc_write_cond & Zero));
  assign MemRead  = ~Reset & mem_read_d;
  assign MemWrite = ~Reset & mem_write_d;
  assign IRWrite  = ~Reset & ir_write_d;
  assign RegWrite = ~Reset & reg_write_d;
  assign Illegal  = ~Reset & illegal_d;

  assign IorD     = iord_d;
  assign MemtoReg = memto_reg_d;
  assign RegDst   = reg_dst_d;
  assign ALUSrcA  = alu_src_a_d;
  assign ALUSrcB  = alu_src_b_d;
  assign ALUOp    = alu_op_d;
  assign PCSource = pc_source_d;
  assign State    = state;

endmodule
